// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority. Secondary results queue in a FIFO and drain into idle WB slots.
// Optional ARB_BYPASS_EN: a secondary result that arrives while the FIFO is empty and the WB slot is idle is written in the same cycle.
module wb_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_arb_wb_we,
  input  logic [4:0]       i_arb_wb_rdst,
  input  logic [WIDTH-1:0] i_arb_wb_data,
  input  logic             i_arb_sec_valid,
  output logic             o_arb_sec_ready,
  input  logic [4:0]       i_arb_sec_rdst,
  input  logic [WIDTH-1:0] i_arb_sec_data,
  input  logic [4:0]       i_arb_chk_reg,
  output logic             o_arb_chk_hit,
  output logic             o_arb_stall,
  output logic             o_arb_rf_we,
  output logic [4:0]       o_arb_rf_rdst,
  output logic [WIDTH-1:0] o_arb_rf_data,
  output logic             o_arb_vwb_we,
  output logic [4:0]       o_arb_vwb_rdst,
  output logic [WIDTH-1:0] o_arb_vwb_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]       rdst_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic empty, full, wb_busy, sec_xfer, pop, push, bypass;

  assign empty           = (count == '0);
  assign full            = (count == FULL_CNT);
  assign wb_busy         = i_arb_wb_we && (i_arb_wb_rdst != 5'd0);
  assign o_arb_sec_ready = !full;
  assign sec_xfer        = i_arb_sec_valid && !full && (i_arb_sec_rdst != 5'd0);
  assign o_arb_stall     = !rst && !empty && (starve_cnt == STARVE_LIM);
  assign push            = sec_xfer && !bypass;

  // A stall steals the slot from WB. Otherwise WB wins, and the FIFO fills idle slots.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    o_arb_rf_we   = 1'b0;
    o_arb_rf_rdst = 5'd0;
    o_arb_rf_data = '0;
    pop           = 1'b0;
    bypass        = 1'b0;
    if (rst) begin
      o_arb_rf_we = 1'b0;
    end else if (o_arb_stall) begin
      o_arb_rf_we   = 1'b1;
      o_arb_rf_rdst = rdst_mem[rd_ptr];
      o_arb_rf_data = data_mem[rd_ptr];
      pop           = 1'b1;
    end else if (wb_busy) begin
      o_arb_rf_we   = 1'b1;
      o_arb_rf_rdst = i_arb_wb_rdst;
      o_arb_rf_data = i_arb_wb_data;
    end else if (!empty) begin
      o_arb_rf_we   = 1'b1;
      o_arb_rf_rdst = rdst_mem[rd_ptr];
      o_arb_rf_data = data_mem[rd_ptr];
      pop           = 1'b1;
`ifdef ARB_BYPASS_EN
    end else if (sec_xfer) begin
      o_arb_rf_we   = 1'b1;
      o_arb_rf_rdst = i_arb_sec_rdst;
      o_arb_rf_data = i_arb_sec_data;
      bypass        = 1'b1;
`endif
    end
  end

  // The lookup covers only entries already stored. A push in the current cycle is not visible yet.
  always_comb begin
    o_arb_chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rdst_mem[i] == i_arb_chk_reg)) o_arb_chk_hit = 1'b1;
    end
    if (i_arb_chk_reg == 5'd0) o_arb_chk_hit = 1'b0;
  end

  // NOTE: the payload storage has no reset. valid_q and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rdst_mem[wr_ptr] <= i_arb_sec_rdst;
      data_mem[wr_ptr] <= i_arb_sec_data;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every read sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || empty)                  starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_arb_vwb_we   <= 1'b0;
      o_arb_vwb_rdst <= 5'd0;
      o_arb_vwb_data <= '0;
    end else begin
      o_arb_vwb_we   <= o_arb_rf_we;
      o_arb_vwb_rdst <= o_arb_rf_rdst;
      o_arb_vwb_data <= o_arb_rf_data;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the pipeline write-back stage (primary, fixed priority) and a long-latency secondary unit (multiply/divide or coprocessor result, valid/ready handshake).
- Secondary results wait in a small FIFO and drain into idle write-back slots.
- A starvation counter forces a one-cycle pipeline stall when the FIFO waits too long.
- Sits between stage_wb and the register file; also provides a one-cycle-late copy of the granted write for forwarding, and a pending-register lookup for hazard detection.

Parameters:
- WIDTH, 32, data width of register-file writes
- DEPTH, 4, secondary FIFO entries (power of two, ≥2)
- STARVE_MAX, 8, cycles a non-empty FIFO may go without a drain before a forced stall (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_arb_wb_we  in  1  pipeline WB write enable
- i_arb_wb_rdst  in  5  pipeline WB destination register
- i_arb_wb_data  in  WIDTH  pipeline WB data
- i_arb_sec_valid  in  1  secondary result valid
- o_arb_sec_ready  out  1  secondary result accepted this cycle
- i_arb_sec_rdst  in  5  secondary destination register
- i_arb_sec_data  in  WIDTH  secondary data
- i_arb_chk_reg  in  5  register to look up in the FIFO
- o_arb_chk_hit  out  1  a valid FIFO entry targets i_arb_chk_reg
- o_arb_stall  out  1  forced pipeline stall (WB slot stolen)
- o_arb_rf_we  out  1  register-file write enable
- o_arb_rf_rdst  out  5  register-file write address
- o_arb_rf_data  out  WIDTH  register-file write data
- o_arb_vwb_we  out  1  o_arb_rf_we delayed one cycle
- o_arb_vwb_rdst  out  5  o_arb_rf_rdst delayed one cycle
- o_arb_vwb_data  out  WIDTH  o_arb_rf_data delayed one cycle

Behaviour:
- Definitions:
  - WB slot busy = i_arb_wb_we && i_arb_wb_rdst != 0.
  - WB writes to r0 count as idle slots and are never driven out.
- Write port:
  - If o_arb_stall = 1: drive the FIFO head; WB inputs are ignored this cycle.
  - Else if WB slot busy: drive the WB inputs.
  - Else if FIFO non-empty: drive the FIFO head and pop it.
  - Else: o_arb_rf_we = 0.
  - Port outputs are combinational from the inputs and registered state.
  - While rst = 1, o_arb_rf_we = 0 and o_arb_stall = 0.
- Secondary handshake:
  - o_arb_sec_ready = !full; it does not depend on a pop in the same cycle.
  - Transfer occurs when valid && ready. The source holds rdst/data until the transfer.
  - A transfer with rdst = 0 is acknowledged and discarded (not enqueued).
  - The enqueued entry is writable from the next cycle: minimum latency is 1 cycle.
- FIFO:
  - DEPTH entries; read/write pointers wrap modulo DEPTH; count is 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Entries drain in order.
- Starvation counter (0..STARVE_MAX):
  - Clears on reset, on any pop, and whenever the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and not popped.
  - o_arb_stall = (counter == STARVE_MAX) && FIFO non-empty; it is a registered-state decode, high for exactly one cycle.
  - The stall cycle pops the head and clears the counter.
  - The pipeline holds its WB contents during o_arb_stall and replays them the next cycle.
- o_arb_chk_hit:
  - Combinational OR over valid entries of (rdst == i_arb_chk_reg).
  - Always 0 when i_arb_chk_reg = 0.
  - Does not include an entry being pushed in the same cycle.
- VWB registers: update every cycle with the current port values. Reset to we = 0, rdst = 0, data = 0.
- Reset mid-operation: the FIFO empties, the counter clears, and all queued results are dropped. The secondary unit is reset by the same rst.

Optional Feature:
- ARB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, the WB slot is idle and a secondary transfer with nonzero rdst occurs, the secondary data is written the same cycle (combinational path from i_arb_sec_*) and is not enqueued.
  - o_arb_chk_hit is unaffected.
- Undefined: every secondary result passes through the FIFO (minimum 1-cycle latency); no combinational path from i_arb_sec_* to o_arb_rf_*.

Test Plan:
- Idle WB; secondary pushes r5 = 0xDEADBEEF at cycle 0 -> cycle 1: o_arb_rf_we = 1, rdst = 5, data = 0xDEADBEEF; cycle 2: vwb mirrors it. With ARB_BYPASS_EN the write appears at cycle 0.
- WB busy (r3 = 0x11) continuously; push r7 = 0x22 -> WB writes each cycle. After STARVE_MAX = 8 waiting cycles o_arb_stall = 1 for one cycle with rdst = 7, data = 0x22, then the WB write resumes; counter back to 0.
- WB busy; push 4 entries (r1..r4) -> ready = 0 after the 4th. Drop WB_we -> drains r1, r2, r3, r4 on consecutive cycles, in order; ready reasserts the cycle after the first pop.
- FIFO holds r9; i_arb_chk_reg = 9 -> hit = 1; after drain -> hit = 0. chk_reg = 0 -> hit = 0. Secondary push to r0 -> ready = 1, no write, count unchanged.
- WB_we = 1 with rdst = 0 and FIFO holds r2 -> r2 drained that cycle; the WB r0 write is never driven.
- FIFO holds 3 entries with counter at 5; assert rst one cycle -> rf_we = 0, stall = 0, ready = 1, chk_hit = 0 and vwb = 0 after reset; no queued entry is ever written.
